melody_player: RTL
==================

MELODY_PLAYER -- requirements
Module: melody_player

Interface
REQ-001 Parameter TICKS_PER_BEAT, default 25_000_000, sys_clk cycles per duration unit (0.5 s at 50 MHz).
REQ-002 Parameter GAP_TICKS, default 1_000_000, silent cycles inserted after every note; 0 means no gap.
REQ-003 Parameter SONG_LEN, default 16, number of entries in melody ROM (2..256).
REQ-004 Parameter DIV_W, default 18, width of tone period counter.
REQ-005 sys_clk  in  1  system clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  single-cycle pulse, begin playback at entry 0.
REQ-008 stop  in  1  single-cycle pulse, abort playback.
REQ-009 loop_en  in  1  1 = restart at entry 0 after last entry; sampled at end of last note.
REQ-010 duty  in  7  PWM high-time percent, 0..100; values >100 treated as 100; sampled at each note start.
REQ-011 beep  out  1  tone output, high during PWM high phase.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 note_idx  out  8  index of entry being played.
REQ-014 done  out  1  one-cycle pulse when playback ends without loop.

Function
REQ-015 ROM entry: pitch[3:0], beats[2:0]; pitch 0 = rest, 1..7 = DO..XI, 8..14 = same notes one octave up (period halved), 15 = rest; beats 0 treated as 1.
REQ-016 Base periods (cycles at 50 MHz): DO 190_839, RE 170_067, MI 151_514, FA 143_265, SO 127_550, LA 113_635, XI 101_214.
REQ-017 States IDLE, PLAY, GAP; IDLE->PLAY on start; PLAY->GAP when note time expires; GAP->PLAY (next entry) after GAP_TICKS; GAP skipped when GAP_TICKS=0.
REQ-018 Note time = beats x TICKS_PER_BEAT cycles exactly; beat counter and tick counter clear at note start.
REQ-019 On note start the tone period counter clears to 0 and high threshold = period x duty / 100 is registered (truncate); arithmetic at DIV_W+7 bits, no overflow.
REQ-020 beep = 1 while period counter < threshold in PLAY with non-rest pitch; 0 in IDLE, GAP and rests; duty 0 gives constant 0, duty 100 constant 1.
REQ-021 Period counter counts 0..period-1 and wraps; wrap independent of note boundaries except REQ-019 clear.
REQ-022 After last entry's note (and gap): loop_en=1 -> note_idx 0, PLAY; loop_en=0 -> IDLE, done pulses 1 cycle, note_idx 0.
REQ-023 stop in any non-IDLE state -> IDLE next cycle, beep 0, no done pulse; stop in IDLE ignored.
REQ-024 start while busy restarts at entry 0 immediately; start and stop same cycle: stop wins.
REQ-025 Output latency: beep reflects new note in the first cycle after state enters PLAY.

Reset
REQ-026 On rst_n low, asynchronously: state IDLE, all counters 0, note_idx 0, beep 0, busy 0, done 0.
REQ-027 Reset mid-note aborts playback; no done pulse on release.

Structure
REQ-028 Shared package melody_pkg holds pitch code constants, base period table, state enumeration and ROM entry field widths.
REQ-029 Sub-module tone_pwm (period, threshold, load pulse, enable -> beep) is instantiated once; melody ROM is a case-based constant table inside melody_player.

Verification (bench overrides TICKS_PER_BEAT=10, GAP_TICKS=2, periods scaled to 10..70)
REQ-030 start, ROM DO/1 beat, duty 30, period 10 -> beep high 3, low 7 cycles, repeats for 10 cycles, then 2 silent gap cycles.
REQ-031 Full 3-entry song, loop_en=0 -> note_idx 0,1,2, done single pulse, busy falls same cycle, beep 0 after.
REQ-032 loop_en=1 -> after entry 2 gap, note_idx returns to 0, no done pulse, busy stays 1.
REQ-033 stop mid-note 2 -> busy 0 and beep 0 next cycle; duty 0 and duty 120 -> beep constant 0 and constant 1 respectively.
REQ-034 Rest entry and pitch 9 (RE high, period 10 from 20) -> beep 0 for full rest, then half period observed.
REQ-035 rst_n asserted mid-note, asynchronously -> all outputs 0 within same cycle, idle after release until start.

Source files
------------

// File: rtl/melody_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : melody_pkg
//  Description : Shared definitions for the melody player: pitch codes,
//                base tone periods, FSM state encoding, ROM entry layout
//                and the pitch-to-period helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package melody_pkg;

    // ROM entry field widths
    localparam int PITCH_W = 4;
    localparam int BEATS_W = 3;
    localparam int IDX_W   = 8;

    // Pitch codes. Codes 8..14 are the same notes one octave up.
    localparam logic [PITCH_W-1:0] PITCH_REST    = 4'd0;
    localparam logic [PITCH_W-1:0] PITCH_DO      = 4'd1;
    localparam logic [PITCH_W-1:0] PITCH_RE      = 4'd2;
    localparam logic [PITCH_W-1:0] PITCH_MI      = 4'd3;
    localparam logic [PITCH_W-1:0] PITCH_FA      = 4'd4;
    localparam logic [PITCH_W-1:0] PITCH_SO      = 4'd5;
    localparam logic [PITCH_W-1:0] PITCH_LA      = 4'd6;
    localparam logic [PITCH_W-1:0] PITCH_XI      = 4'd7;
    localparam logic [PITCH_W-1:0] PITCH_OCT_OFS = 4'd7;
    localparam logic [PITCH_W-1:0] PITCH_REST_HI = 4'd15;

    // Base tone periods in sys_clk cycles at 50 MHz
    localparam int unsigned PERIOD_DO = 190_839;
    localparam int unsigned PERIOD_RE = 170_067;
    localparam int unsigned PERIOD_MI = 151_514;
    localparam int unsigned PERIOD_FA = 143_265;
    localparam int unsigned PERIOD_SO = 127_550;
    localparam int unsigned PERIOD_LA = 113_635;
    localparam int unsigned PERIOD_XI = 101_214;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [PITCH_W-1:0] pitch;
        logic [BEATS_W-1:0] beats;
    } rom_entry_t;

    function automatic logic is_rest(input logic [PITCH_W-1:0] pitch);
        return (pitch == PITCH_REST) || (pitch == PITCH_REST_HI);
    endfunction

    // Tone period for a pitch code. With sim set, the scale is compressed
    // to 10,20,..,70 cycles so short simulations still see whole periods.
    function automatic int unsigned note_period(input logic [PITCH_W-1:0] pitch,
                                                input logic               sim);
        logic [PITCH_W-1:0] tone;
        int unsigned        base;
        tone = (pitch > PITCH_XI) ? PITCH_W'(pitch - PITCH_OCT_OFS) : pitch;
        case (tone)
            PITCH_DO: base = sim ? 32'd10 : PERIOD_DO;
            PITCH_RE: base = sim ? 32'd20 : PERIOD_RE;
            PITCH_MI: base = sim ? 32'd30 : PERIOD_MI;
            PITCH_FA: base = sim ? 32'd40 : PERIOD_FA;
            PITCH_SO: base = sim ? 32'd50 : PERIOD_SO;
            PITCH_LA: base = sim ? 32'd60 : PERIOD_LA;
            PITCH_XI: base = sim ? 32'd70 : PERIOD_XI;
            default:  base = 32'd0;
        endcase
        if (is_rest(pitch)) begin
            base = 32'd0;
        end else if (pitch > PITCH_XI) begin
            base = base >> 1;
        end
        return base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/melody_player_tone_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tone_pwm
//  Description : Free-running tone period counter with PWM comparator.
//                load_i clears the counter and captures a new period and
//                high-time threshold; beep_o is high while the counter is
//                below the threshold and en_i is set.
//  Ports       : sys_clk, rst_n (async, active-low)
//                period_i, thresh_i - new note period / high time
//                load_i             - capture pulse at note start
//                en_i               - gate for the tone output
//                beep_o             - PWM tone output
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_pwm
    import melody_pkg::*;
#(
    parameter int DIV_W = 18
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] period_i,
    input  logic [DIV_W-1:0] thresh_i,
    input  logic             load_i,
    input  logic             en_i,
    output logic             beep_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] period_q;
    logic [DIV_W-1:0] thresh_q;

    // A zero period (rest) parks the counter at 0.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (period_q != '0) begin
            cnt_d = (cnt_q >= period_q - 1'b1) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            period_q <= '0;
            thresh_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (load_i) begin
                period_q <= period_i;
                thresh_q <= thresh_i;
            end
        end
    end

    assign beep_o = en_i && (cnt_q < thresh_q);

endmodule
`default_nettype wire

// File: rtl/melody_player.sv
`default_nettype none
// ============================================================================
//  Module      : melody_player
//  Description : Plays a fixed melody from an internal ROM as a PWM tone.
//                Each entry plays for beats x TICKS_PER_BEAT cycles followed
//                by GAP_TICKS silent cycles. Optional looping.
//  Ports       : sys_clk, rst_n (async, active-low)
//                start    - pulse, (re)start at entry 0
//                stop     - pulse, abort playback (wins over start)
//                loop_en  - restart after the last entry instead of ending
//                duty     - PWM high percent, captured at each note start
//                beep     - tone output
//                busy     - playback in progress
//                note_idx - ROM index being played
//                done     - one-cycle pulse when playback ends without loop
//  Revision    : 1.0 - initial release
// ============================================================================
module melody_player
    import melody_pkg::*;
#(
    parameter int TICKS_PER_BEAT = 25_000_000,
    parameter int GAP_TICKS      = 1_000_000,
    parameter int SONG_LEN       = 16,
    parameter int DIV_W          = 18,
    parameter bit SIM_PERIODS    = 1'b0
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [6:0]       duty,
    output logic             beep,
    output logic             busy,
    output logic [IDX_W-1:0] note_idx,
    output logic             done
);

    localparam int TICK_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int PROD_W = DIV_W + 7;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = (GAP_TICKS > 0) ? GAP_W'(GAP_TICKS - 1) : '0;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SONG_LEN - 1);

    // ------------------------------------------------------------------
    // Melody ROM
    // ------------------------------------------------------------------
    function automatic rom_entry_t rom_lookup(input logic [IDX_W-1:0] idx);
        rom_entry_t e;
        case (idx)
            8'd0:    e = '{PITCH_DO,                           3'd1};
            8'd1:    e = '{PITCH_REST,                         3'd0};
            8'd2:    e = '{PITCH_W'(PITCH_RE + PITCH_OCT_OFS), 3'd2};
            8'd3:    e = '{PITCH_MI,                           3'd1};
            8'd4:    e = '{PITCH_FA,                           3'd1};
            8'd5:    e = '{PITCH_SO,                           3'd2};
            8'd6:    e = '{PITCH_LA,                           3'd1};
            8'd7:    e = '{PITCH_XI,                           3'd1};
            8'd8:    e = '{PITCH_W'(PITCH_DO + PITCH_OCT_OFS), 3'd2};
            8'd9:    e = '{PITCH_REST,                         3'd1};
            8'd10:   e = '{PITCH_SO,                           3'd1};
            8'd11:   e = '{PITCH_MI,                           3'd1};
            8'd12:   e = '{PITCH_RE,                           3'd1};
            8'd13:   e = '{PITCH_DO,                           3'd2};
            8'd14:   e = '{PITCH_REST_HI,                      3'd1};
            8'd15:   e = '{PITCH_DO,                           3'd4};
            default: e = '{PITCH_REST,                         3'd1};
        endcase
        return e;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [BEATS_W-1:0] beat_q, beat_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               loop_q, loop_d;
    logic               done_q, done_d;

    rom_entry_t         w_cur;
    rom_entry_t         w_nxt;
    logic [BEATS_W-1:0] w_beats_last;
    logic               w_note_end;
    logic               w_adv;
    logic               w_adv_loop;
    logic               w_load;
    logic [DIV_W-1:0]   w_period;
    logic [6:0]         w_duty;
    logic [PROD_W-1:0]  w_prod;
    logic [DIV_W-1:0]   w_thresh;
    logic               w_tone_en;

    assign w_cur        = rom_lookup(idx_q);
    assign w_beats_last = (w_cur.beats == '0) ? '0 : w_cur.beats - 1'b1;
    assign w_note_end   = (tick_q == TICK_LAST) && (beat_q == w_beats_last);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tick_d     = tick_q;
        beat_d     = beat_q;
        gap_d      = gap_q;
        loop_d     = loop_q;
        done_d     = 1'b0;
        w_load     = 1'b0;
        w_adv      = 1'b0;
        w_adv_loop = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            tick_d  = '0;
            beat_d  = '0;
            gap_d   = '0;
        end else if (start) begin
            state_d = ST_PLAY;
            idx_d   = '0;
            tick_d  = '0;
            beat_d  = '0;
            gap_d   = '0;
            w_load  = 1'b1;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (w_note_end) begin
                        tick_d = '0;
                        beat_d = '0;
                        gap_d  = '0;
                        // Latched at every note end; only the value captured
                        // at the end of the last entry is ever consulted.
                        loop_d = loop_en;
                        if (GAP_TICKS == 0) begin
                            w_adv      = 1'b1;
                            w_adv_loop = loop_en;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        beat_d = beat_q + 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        w_adv      = 1'b1;
                        w_adv_loop = loop_q;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                ST_IDLE: ;
                default: state_d = ST_IDLE;
            endcase

            if (w_adv) begin
                if (idx_q != IDX_LAST) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_PLAY;
                    w_load  = 1'b1;
                end else if (w_adv_loop) begin
                    idx_d   = '0;
                    state_d = ST_PLAY;
                    w_load  = 1'b1;
                end else begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            tick_q  <= '0;
            beat_q  <= '0;
            gap_q   <= '0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Tone setup for the note about to start (entry selected by idx_d)
    // ------------------------------------------------------------------
    assign w_nxt     = rom_lookup(idx_d);
    assign w_period  = DIV_W'(note_period(w_nxt.pitch, SIM_PERIODS));
    assign w_duty    = (duty > 7'd100) ? 7'd100 : duty;
    assign w_prod    = PROD_W'(w_period) * PROD_W'(w_duty);
    assign w_thresh  = DIV_W'(w_prod / PROD_W'(100));
    assign w_tone_en = (state_q == ST_PLAY) && !is_rest(w_cur.pitch);

    tone_pwm #(
        .DIV_W (DIV_W)
    ) u_tone_pwm (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .period_i (w_period),
        .thresh_i (w_thresh),
        .load_i   (w_load),
        .en_i     (w_tone_en),
        .beep_o   (beep)
    );

    assign busy     = (state_q != ST_IDLE);
    assign note_idx = idx_q;
    assign done     = done_q;

endmodule
`default_nettype wire
